// File: rtl/shift_reg_pkg.sv
// rtl/shift_reg_pkg.sv - op codes and FSM state encodings for the shift register sequencer
package shift_reg_pkg;

    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_SHR  = 3'd3;
    localparam logic [2:0] OP_SAR  = 3'd4;
    localparam logic [2:0] OP_ROL  = 3'd5;
    localparam logic [2:0] OP_ROR  = 3'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic is_shift_op(input logic [2:0] op);
        return (op >= OP_SHL) && (op <= OP_ROR);
    endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-bit shift/rotate step
module shift_step
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       op,
    input  logic             serial_in,
    output logic [WIDTH-1:0] next_q,
    output logic             out_bit
);

    always_comb begin
        next_q  = q;
        out_bit = 1'b0;
        case (op)
            OP_SHL: begin
                next_q  = {q[WIDTH-2:0], serial_in};
                out_bit = q[WIDTH-1];
            end
            OP_SHR: begin
                next_q  = {serial_in, q[WIDTH-1:1]};
                out_bit = q[0];
            end
            OP_SAR: begin
                next_q  = {q[WIDTH-1], q[WIDTH-1:1]};
                out_bit = q[0];
            end
            OP_ROL: begin
                next_q  = {q[WIDTH-2:0], q[WIDTH-1]};
                out_bit = q[WIDTH-1];
            end
            OP_ROR: begin
                next_q  = {q[0], q[WIDTH-1:1]};
                out_bit = q[0];
            end
            default: begin
                next_q  = q;
                out_bit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_reg_seq.sv
// rtl/shift_reg_seq.sv - multi-mode shift register with start/busy/done shift sequencer
module shift_reg_seq
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] load_data,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [2:0]         op_lat, op_lat_n;
    logic [WIDTH-1:0]   q_n;
    logic               serial_out_n, busy_n, done_n;
    logic [WIDTH-1:0]   step_q;
    logic               step_out;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .q         (q),
        .op        (op_lat),
        .serial_in (serial_in),
        .next_q    (step_q),
        .out_bit   (step_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            op_lat     <= OP_HOLD;
            q          <= '0;
            serial_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            op_lat     <= op_lat_n;
            q          <= q_n;
            serial_out <= serial_out_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        op_lat_n     = op_lat;
        q_n          = q;
        serial_out_n = serial_out;
        busy_n       = busy;
        done_n       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (op == OP_LOAD) begin
                        q_n    = load_data;
                        done_n = 1'b1;
                    end else if (is_shift_op(op) && (amount != '0)) begin
                        op_lat_n = op;
                        cnt_n    = amount;
                        state_n  = ST_RUN;
                        busy_n   = 1'b1;
                    end else begin
                        // HOLD, reserved, or a zero-length shift: complete at once
                        done_n = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                q_n          = step_q;
                serial_out_n = step_out;
                cnt_n        = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_n = ST_IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_reg_seq.sv
// tb/tb_shift_reg_seq.sv - directed self-checking bench for shift_reg_seq
module tb_shift_reg_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic [3:0] amount;
    logic [7:0] load_data;
    logic       serial_in;
    logic [7:0] q;
    logic       serial_out;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;
    int done_cnt;

    always #5 clk = ~clk;

    shift_reg_seq #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .amount     (amount),
        .load_data  (load_data),
        .serial_in  (serial_in),
        .q          (q),
        .serial_out (serial_out),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [3:0] a, input logic [7:0] d);
        start     = 1'b1;
        op        = o;
        amount    = a;
        load_data = d;
        step();
        start     = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        op        = 3'd0;
        amount    = 4'd0;
        load_data = 8'h00;
        serial_in = 1'b0;
        #2;
        chk8("rst_q", q, 8'h00);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_so", serial_out, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // LOAD
        issue(3'd1, 4'd0, 8'hA5);
        chk8("load_q", q, 8'hA5);
        chk1("load_done", done, 1'b1);
        chk1("load_busy", busy, 1'b0);
        chk1("load_so", serial_out, 1'b0);
        step();
        chk1("load_done_drop", done, 1'b0);
        chk1("load_busy_after", busy, 1'b0);

        // SHL by 3 with fill 1
        issue(3'd1, 4'd0, 8'h81);
        serial_in = 1'b1;
        issue(3'd2, 4'd3, 8'h00);
        chk1("shl_e0_busy", busy, 1'b1);
        chk8("shl_e0_q", q, 8'h81);
        chk1("shl_e0_done", done, 1'b0);
        step();
        chk8("shl_e1_q", q, 8'h03);
        chk1("shl_e1_so", serial_out, 1'b1);
        step();
        chk8("shl_e2_q", q, 8'h07);
        chk1("shl_e2_busy", busy, 1'b1);
        step();
        chk8("shl_e3_q", q, 8'h0F);
        chk1("shl_e3_so", serial_out, 1'b0);
        chk1("shl_e3_busy", busy, 1'b0);
        chk1("shl_e3_done", done, 1'b1);
        step();
        chk1("shl_e4_done", done, 1'b0);

        // SAR by 2
        issue(3'd1, 4'd0, 8'h90);
        issue(3'd4, 4'd2, 8'h00);
        step();
        chk8("sar_e1_q", q, 8'hC8);
        step();
        chk8("sar_e2_q", q, 8'hE4);
        chk1("sar_e2_so", serial_out, 1'b0);
        chk1("sar_e2_done", done, 1'b1);

        // ROR by 1
        issue(3'd1, 4'd0, 8'h01);
        issue(3'd6, 4'd1, 8'h00);
        step();
        chk8("ror_q", q, 8'h80);
        chk1("ror_so", serial_out, 1'b1);
        chk1("ror_done", done, 1'b1);
        chk1("ror_busy", busy, 1'b0);

        // ROL by 8 wraps to original
        issue(3'd1, 4'd0, 8'h5A);
        issue(3'd5, 4'd8, 8'h00);
        for (int i = 0; i < 7; i++) step();
        chk1("rol_e7_busy", busy, 1'b1);
        chk1("rol_e7_done", done, 1'b0);
        step();
        chk8("rol_q", q, 8'h5A);
        chk1("rol_so", serial_out, 1'b0);
        chk1("rol_done", done, 1'b1);

        // zero amount and reserved op complete immediately
        issue(3'd1, 4'd0, 8'h3C);
        issue(3'd3, 4'd0, 8'h00);
        chk1("amt0_done", done, 1'b1);
        chk1("amt0_busy", busy, 1'b0);
        chk8("amt0_q", q, 8'h3C);
        step();
        chk1("amt0_done_drop", done, 1'b0);
        issue(3'd7, 4'd5, 8'hFF);
        chk1("op7_done", done, 1'b1);
        chk1("op7_busy", busy, 1'b0);
        chk8("op7_q", q, 8'h3C);

        // serial_in sampled on every RUN edge
        issue(3'd1, 4'd0, 8'h00);
        serial_in = 1'b1;
        issue(3'd3, 4'd2, 8'h00);
        step();
        chk8("shr_si_e1", q, 8'h80);
        serial_in = 1'b0;
        step();
        chk8("shr_si_e2", q, 8'h40);

        // start during RUN is ignored
        issue(3'd1, 4'd0, 8'h01);
        serial_in = 1'b0;
        issue(3'd2, 4'd4, 8'h00);
        done_cnt = 0;
        step();
        if (done) done_cnt++;
        start     = 1'b1;
        op        = 3'd1;
        load_data = 8'hFF;
        step();
        start     = 1'b0;
        if (done) done_cnt++;
        chk8("busy_ign_e2_q", q, 8'h04);
        step();
        if (done) done_cnt++;
        step();
        if (done) done_cnt++;
        chk8("busy_ign_e4_q", q, 8'h10);
        step();
        if (done) done_cnt++;
        chk8("busy_ign_done_cnt", 8'(done_cnt), 8'd1);
        chk8("busy_ign_final_q", q, 8'h10);

        // asynchronous reset mid-RUN
        issue(3'd1, 4'd0, 8'hFF);
        issue(3'd3, 4'd5, 8'h00);
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        chk8("arst_q", q, 8'h00);
        chk1("arst_busy", busy, 1'b0);
        chk1("arst_done", done, 1'b0);
        chk1("arst_so", serial_out, 1'b0);
        step();
        step();
        @(negedge clk);
        reset = 1'b0;
        #1;
        step();
        chk1("arst_no_done", done, 1'b0);
        issue(3'd1, 4'd0, 8'h12);
        chk8("post_rst_load", q, 8'h12);
        issue(3'd4, 4'd1, 8'h00);
        step();
        chk8("post_rst_sar_q", q, 8'h09);
        chk1("post_rst_sar_so", serial_out, 1'b0);
        chk1("post_rst_sar_done", done, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
